store_rmw_ctrl: RTL

//  Read-modify-write sequencer for sub-doubleword stores to the 64-bit data memory.
//  - Accepts one store request: address, 64-bit register data and size code.
//  - Reads the target memory doubleword and merges the low 32/16/8 bits of the store data into it.
//  - Writes the merged doubleword back and pulses done.
//  - Sits between the execute stage's store issue and the data memory port.

---
 rtl/rmw_pkg.sv | 27 ++
 rtl/rmw_lane_merge.sv | 23 ++
 rtl/store_rmw_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/rmw_pkg.sv
// Shared types for the store read-modify-write controller: store size codes,
// FSM state encoding and the doubleword width.
package rmw_pkg;

  localparam int DWORD_W = 64;

  typedef enum logic [2:0] {
    SZ_D = 3'b000,
    SZ_W = 3'b001,
    SZ_H = 3'b010,
    SZ_B = 3'b011
  } store_size_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } rmw_state_e;

  // Any size code with the top bit set has no defined lane width.
  function automatic logic size_is_illegal(input logic [2:0] size);
    return size[2];
  endfunction

endpackage

// File: rtl/rmw_lane_merge.sv
// Combinational lane-0 merge of store data into an old memory doubleword.
module rmw_lane_merge
  import rmw_pkg::*;
(
  input  logic [DWORD_W-1:0] old_word,
  input  logic [DWORD_W-1:0] st_data,
  input  logic [2:0]         size,
  output logic [DWORD_W-1:0] merged
);

  // Select how many low bits of the store data replace the old word.
  always_comb begin
    merged = old_word;
    case (size)
      SZ_D:    merged = st_data;
      SZ_W:    merged = {old_word[63:32], st_data[31:0]};
      SZ_H:    merged = {old_word[63:16], st_data[15:0]};
      SZ_B:    merged = {old_word[63:8],  st_data[7:0]};
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/store_rmw_ctrl.sv
// Read-modify-write sequencer for sub-doubleword stores to 64-bit data memory.
// Optional macro RMW_DWORD_BYPASS_EN: full-doubleword stores skip the read.
module store_rmw_ctrl
  import rmw_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 64,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [2:0]        req_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              done,
  output logic              err,
  output logic              busy
);

`ifdef RMW_DWORD_BYPASS_EN
  localparam logic BYPASS_EN = 1'b1;
`else
  localparam logic BYPASS_EN = 1'b0;
`endif

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

  rmw_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [2:0]        size_q, size_d;
  logic [DATA_W-1:0] rdw_q, rdw_d;
  logic [2:0]        lat_cnt_q, lat_cnt_d;
  logic              err_d;

  logic              req_ready_q, req_ready_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic              mem_wr_en_q, mem_wr_en_d;
  logic [DATA_W-1:0] mem_wr_data_q, mem_wr_data_d;
  logic              done_q, done_d;
  logic              err_q;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] merged;

  // Next-state and operand capture for the RMW sequence.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    size_d    = size_q;
    rdw_d     = rdw_q;
    lat_cnt_d = lat_cnt_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d = req_addr;
          data_d = req_data;
          size_d = req_size;
          if (size_is_illegal(req_size)) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else if (BYPASS_EN && (req_size == SZ_D)) begin
            state_d = WR;
          end else begin
            state_d = RD_REQ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD_REQ: begin
        lat_cnt_d = LAT_INIT;
        state_d   = RD_WAIT;
      end
      RD_WAIT: begin
        if (lat_cnt_q == 3'd0) begin
          rdw_d   = mem_rd_data;
          state_d = WR;
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Merge sees the word being captured this cycle so the write data is ready in WR.
  rmw_lane_merge u_merge (
    .old_word (rdw_d),
    .st_data  (data_d),
    .size     (size_d),
    .merged   (merged)
  );

  // Outputs are decoded from the next state so they come straight from flops.
  always_comb begin
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    mem_rd_en_d = (state_d == RD_REQ);
    mem_wr_en_d = (state_d == WR);
    done_d      = (state_d == RESP);
    if (state_d == WR) begin
      mem_wr_data_d = merged;
    end else begin
      mem_wr_data_d = mem_wr_data_q;
    end
  end

  // State, operand and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      data_q        <= '0;
      size_q        <= 3'b000;
      rdw_q         <= '0;
      lat_cnt_q     <= 3'd0;
      req_ready_q   <= 1'b1;
      mem_rd_en_q   <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_wr_data_q <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      size_q        <= size_d;
      rdw_q         <= rdw_d;
      lat_cnt_q     <= lat_cnt_d;
      req_ready_q   <= req_ready_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_wr_data_q <= mem_wr_data_d;
      done_q        <= done_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign mem_addr    = addr_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_wr_data = mem_wr_data_q;
  assign done        = done_q;
  assign err         = err_q;
  assign busy        = busy_q;

endmodule
